// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: bubble/reset defaults, instruction field
// positions and the fetch FSM encoding.
package rv32i_pkg;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int F3_LSB  = 12;
  localparam int F3_MSB  = 14;
  localparam int F7_BIT  = 30;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a word accepted from imem while IF/ID is stalled.
module fetch_skid_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= 32'h0;
      instr <= 32'h0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= d_pc;
      instr <= d_instr;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch with IF/ID register, imem req/ready handshake,
// stall skid, and redirect with drop of an in-flight response.
module fetch_stage
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        pcSrc,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic        func7
);
  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n, drop_addr, drop_addr_n;
  logic         drop, drop_n;
  logic         ifv_n;
  logic [31:0]  ifpc_n, ifi_n;
  logic         skid_load, skid_clear, skid_valid;
  logic [31:0]  skid_pc, skid_instr;

  fetch_skid_buffer u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .clear   (skid_clear),
    .d_pc    (pc),
    .d_instr (imem_rdata),
    .valid   (skid_valid),
    .pc      (skid_pc),
    .instr   (skid_instr)
  );

  // Outputs come from registers only; while dropping, the old address is
  // held so the outstanding request stays stable until its ready.
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = drop ? drop_addr : pc;

  assign opcode = if_id_instr[OPC_MSB:OPC_LSB];
  assign func3  = if_id_instr[F3_MSB:F3_LSB];
  assign func7  = if_id_instr[F7_BIT];

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    drop_n      = drop;
    drop_addr_n = drop_addr;
    ifv_n       = if_id_valid;
    ifpc_n      = if_id_pc;
    ifi_n       = if_id_instr;
    skid_load   = 1'b0;
    skid_clear  = 1'b0;

    case (state)
      S_BOOT: state_n = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          if (drop) begin
            drop_n = 1'b0;
          end else if (!pcSrc && !flush) begin
            pc_n = pc + 32'd4;
            if (stall) begin
              skid_load = 1'b1;
              state_n   = S_HOLD;
            end else begin
              ifv_n  = 1'b1;
              ifpc_n = pc;
              ifi_n  = imem_rdata;
            end
          end
        end
      end
      S_HOLD: begin
        if (!stall || flush) begin
          state_n    = S_FETCH;
          skid_clear = 1'b1;
          if (!flush) begin
            ifv_n  = skid_valid;
            ifpc_n = skid_pc;
            ifi_n  = skid_instr;
          end
        end
      end
      default: state_n = S_BOOT;
    endcase

    // Redirect overrides the accept path; a response still owed for the old
    // address must be swallowed before the target is requested.
    if (pcSrc) begin
      pc_n        = branch_target & ~32'h3;
      skid_clear  = 1'b1;
      state_n     = S_FETCH;
      drop_n      = imem_req && !imem_ready;
      drop_addr_n = imem_addr;
    end

    if (flush) begin
      ifv_n      = 1'b0;
      ifi_n      = NOP_INSTR;
      skid_clear = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      drop        <= 1'b0;
      drop_addr   <= RESET_PC;
      if_id_valid <= 1'b0;
      if_id_pc    <= RESET_PC;
      if_id_instr <= NOP_INSTR;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      drop        <= drop_n;
      drop_addr   <= drop_addr_n;
      if_id_valid <= ifv_n;
      if_id_pc    <= ifpc_n;
      if_id_instr <= ifi_n;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage with a per-cycle IF/ID scoreboard.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, stall, pcSrc, flush, imem_ready;
  logic [31:0] branch_target, imem_addr, imem_rdata, if_id_pc, if_id_instr;
  logic        imem_req, if_id_valid, func7;
  logic [6:0]  opcode;
  logic [2:0]  func3;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // Memory model: word content derived from its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction
  assign imem_rdata = mem_word(imem_addr);

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pcSrc(pcSrc), .flush(flush),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_id_valid(if_id_valid),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .opcode(opcode),
    .func3(func3), .func7(func7)
  );

  typedef struct {
    logic [3:0]  ctl;   // {ready, stall, pcSrc, flush}
    logic [31:0] bt;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  typedef struct {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  vec_t tbl[23];
  exp_t sb[$];

  function automatic vec_t v(input logic [3:0] ctl, input logic [31:0] bt,
                             input logic req, input logic [31:0] addr,
                             input logic vld, input logic [31:0] pc);
    vec_t r;
    r.ctl = ctl; r.bt = bt; r.req = req; r.addr = addr; r.vld = vld; r.pc = pc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_ifid(input exp_t e);
    chk("if_id_valid", 32'(if_id_valid), 32'(e.vld));
    chk("if_id_pc", if_id_pc, e.pc);
    chk("if_id_instr", if_id_instr, e.instr);
    chk("opcode", 32'(opcode), 32'(e.instr[6:0]));
    chk("func3", 32'(func3), 32'(e.instr[14:12]));
    chk("func7", 32'(func7), 32'(e.instr[30]));
  endtask

  task automatic chk_reset_outputs();
    exp_t e;
    e.vld = 1'b0; e.pc = 32'h0; e.instr = NOP;
    chk("rst imem_req", 32'(imem_req), 32'h0);
    chk("rst imem_addr", imem_addr, 32'h0);
    chk_ifid(e);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; stall = 1'b0; pcSrc = 1'b0; flush = 1'b0;
    imem_ready = 1'b0; branch_target = 32'h0;

    //            {rdy,stl,ps,fl} bt           req   addr          vld   if_id_pc
    tbl[0]  = v(4'b1000, 32'h0,   1'b0, 32'h000, 1'b0, 32'h000); // boot idle
    tbl[1]  = v(4'b1000, 32'h0,   1'b1, 32'h000, 1'b1, 32'h000);
    tbl[2]  = v(4'b1000, 32'h0,   1'b1, 32'h004, 1'b1, 32'h004);
    tbl[3]  = v(4'b0000, 32'h0,   1'b1, 32'h008, 1'b1, 32'h004); // wait states
    tbl[4]  = v(4'b0000, 32'h0,   1'b1, 32'h008, 1'b1, 32'h004);
    tbl[5]  = v(4'b0000, 32'h0,   1'b1, 32'h008, 1'b1, 32'h004);
    tbl[6]  = v(4'b1000, 32'h0,   1'b1, 32'h008, 1'b1, 32'h008);
    tbl[7]  = v(4'b1000, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h00C);
    tbl[8]  = v(4'b1100, 32'h0,   1'b1, 32'h010, 1'b1, 32'h00C); // stall on accept
    tbl[9]  = v(4'b1100, 32'h0,   1'b0, 32'h014, 1'b1, 32'h00C); // S_HOLD
    tbl[10] = v(4'b0000, 32'h0,   1'b0, 32'h014, 1'b1, 32'h010); // skid drains
    tbl[11] = v(4'b1000, 32'h0,   1'b1, 32'h014, 1'b1, 32'h014);
    tbl[12] = v(4'b1000, 32'h0,   1'b1, 32'h018, 1'b1, 32'h018);
    tbl[13] = v(4'b1000, 32'h0,   1'b1, 32'h01C, 1'b1, 32'h01C);
    tbl[14] = v(4'b1011, 32'h102, 1'b1, 32'h020, 1'b0, 32'h01C); // taken branch
    tbl[15] = v(4'b1000, 32'h0,   1'b1, 32'h100, 1'b1, 32'h100);
    tbl[16] = v(4'b1000, 32'h0,   1'b1, 32'h104, 1'b1, 32'h104);
    tbl[17] = v(4'b1011, 32'h030, 1'b1, 32'h108, 1'b0, 32'h104);
    tbl[18] = v(4'b0011, 32'h200, 1'b1, 32'h030, 1'b0, 32'h104); // redirect on miss
    tbl[19] = v(4'b0000, 32'h0,   1'b1, 32'h030, 1'b0, 32'h104);
    tbl[20] = v(4'b1000, 32'h0,   1'b1, 32'h030, 1'b0, 32'h104); // dropped
    tbl[21] = v(4'b1000, 32'h0,   1'b1, 32'h200, 1'b1, 32'h200);
    tbl[22] = v(4'b1100, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200); // into S_HOLD

    @(posedge clk); @(posedge clk); #1;
    chk_reset_outputs();
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      {imem_ready, stall, pcSrc, flush} = tbl[i].ctl;
      branch_target = tbl[i].bt;
      e.vld = tbl[i].vld;
      e.pc = tbl[i].pc;
      e.instr = tbl[i].vld ? mem_word(tbl[i].pc) : NOP;
      sb.push_back(e);
      #4;
      chk($sformatf("imem_req[%0d]", i), 32'(imem_req), 32'(tbl[i].req));
      chk($sformatf("imem_addr[%0d]", i), imem_addr, tbl[i].addr);
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL scoreboard underflow at %0d", i);
      end else begin
        e = sb.pop_front();
        chk_ifid(e);
      end
    end

    // Asynchronous reset between edges while in S_HOLD.
    imem_ready = 1'b0; stall = 1'b1; pcSrc = 1'b0; flush = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1; stall = 1'b0;
    #4 chk("reboot idle req", 32'(imem_req), 32'h0);
    @(posedge clk); #5;
    chk("reboot req", 32'(imem_req), 32'h1);
    chk("reboot addr", imem_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage with IF/ID pipeline register for the RV32I core.
- Holds the PC and runs a req/ready handshake to instruction memory. Registers the fetched word and PC into IF/ID, and presents decoded opcode/func3/func7 to the downstream control unit.
- Consumes the control unit's pcSrc/flush and a branch target; consumes a stall from the hazard logic.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble word (addi x0,x0,0) inserted on reset/flush.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold IF/ID and PC (downstream not accepting)
- pcSrc  in  1  redirect PC to branch_target
- flush  in  1  kill instruction in IF/ID
- branch_target  in  32  redirect address from EX
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (word aligned)
- imem_ready  in  1  memory accepted request; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction
- if_id_valid  out  1  IF/ID holds a live instruction
- if_id_pc  out  32  PC of IF/ID instruction
- if_id_instr  out  32  IF/ID instruction word
- opcode  out  7  if_id_instr[6:0]
- func3  out  3  if_id_instr[14:12]
- func7  out  1  if_id_instr[30]

Behaviour:
- Reset (async assert, sync deassert internally, any state): pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc=RESET_PC, if_id_valid=0, imem_req=0, skid empty, drop=0, state=S_BOOT.
- opcode/func3/func7 are combinational slices of if_id_instr; reset gives 7'h13/3'b000/0.
- FSM states: S_BOOT, S_FETCH, S_HOLD.
- S_BOOT:
  - One idle cycle after reset release with imem_req=0.
  - Then S_FETCH.
- S_FETCH:
  - imem_req=1, imem_addr=pc.
  - Address is held stable until imem_ready=1.
  - Minimum latency is one cycle: request accepted at edge N, instruction in IF/ID after edge N.
- Accept in S_FETCH (imem_ready=1, drop=0, pcSrc=0, stall=0):
  - if_id_instr<=imem_rdata, if_id_pc<=pc, if_id_valid<=1, pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC->0).
- Accept in S_FETCH with stall=1:
  - Word and pc go to the skid buffer; IF/ID unchanged; pc<=pc+4; go to S_HOLD.
- S_HOLD:
  - imem_req=0.
  - When stall=0: IF/ID<=skid, valid<=1, skid cleared, go to S_FETCH.
- Stall with no accept: IF/ID and pc hold; request may remain outstanding.
- Redirect (pcSrc=1), priority over stall:
  - pc<=branch_target with bits[1:0] forced to 0.
  - Skid is cleared; state goes to S_FETCH.
  - If a request is outstanding and not ready this cycle, set drop=1.
  - When drop=1, the next imem_ready response is discarded, drop clears, and the target is then requested. imem_addr keeps the old address until that ready.
  - A ready in the same cycle as pcSrc is discarded.
- Flush=1:
  - if_id_instr<=NOP_INSTR, if_id_valid<=0, regardless of stall; skid cleared.
  - flush together with an accept (same cycle): the accepted word is discarded, not loaded.
- flush without pcSrc: pc unchanged. The two are normally asserted together.
- Back-to-back redirects: the latest branch_target wins; drop stays 1 until one response has been absorbed.
- No combinational path from stall/pcSrc/flush to imem_req or imem_addr.

Decomposition:
- Shared package (rv32i_pkg):
  - NOP_INSTR, RESET_PC defaults.
  - Opcode field positions (OPC_LSB/MSB, F3_LSB/MSB, F7_BIT).
  - Fetch FSM state encoding (2 bits).
- One sub-module: fetch_skid_buffer (1-entry valid+pc+instr holding register with load/clear).

Test Plan:
- Reset and zero-wait streaming:
  - Release rst_n, imem_ready=1, imem_rdata=addr-derived.
  - Required: imem_req=0 for 1 cycle; imem_addr 0x0,0x4,0x8; if_id_pc follows one cycle later with if_id_valid=1.
- Wait states:
  - imem_ready low 3 cycles at addr 0x8.
  - Required: imem_addr stays 0x8, IF/ID holds the 0x4 word, no duplicate or skipped PC.
- Stall during accept:
  - stall=1 on the cycle 0x10 returns.
  - Required: IF/ID keeps the 0xC word, state S_HOLD, imem_req=0.
  - On stall=0: IF/ID gets 0x10, next request is 0x14.
- Taken branch:
  - pcSrc=flush=1, branch_target=0x102 while ready for 0x20.
  - Required: 0x20 word discarded, if_id_valid=0, instr=0x00000013, next imem_addr=0x100.
- Redirect with outstanding miss:
  - pcSrc at addr 0x30 with ready=0, then ready 2 cycles later.
  - Required: that response is dropped, the next request is to the target, and no instruction from 0x30 reaches IF/ID.
- Async reset mid-S_HOLD:
  - Drop rst_n between clock edges.
  - Required: all outputs return to reset values immediately, without waiting for a clock edge.
